// File: rtl/pla_pkg.sv
`default_nettype none
// ============================================================================
// pla_pkg: shared defaults, FSM state encoding and Cfg_Sel plane selectors
//          for the programmable PLA decoder.
// Rev 1.0
// ============================================================================
package pla_pkg;

    localparam int C_PLA_N_IN   = 6;
    localparam int C_PLA_N_OUT  = 48;
    localparam int C_PLA_N_TERM = 64;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pla_state_t;

    localparam logic C_SEL_AND = 1'b0;
    localparam logic C_SEL_OR  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pla_and_plane.sv
`default_nettype none
// ============================================================================
// pla_and_plane: Care/Val/En term storage with combinational term evaluation.
// Rev 1.0
// ============================================================================
module pla_and_plane
    import pla_pkg::*;
#(
    parameter int N_IN   = C_PLA_N_IN,
    parameter int N_TERM = C_PLA_N_TERM,
    parameter int TW     = $clog2(N_TERM)
) (
    input  logic              Clk,
    input  logic              i_we,
    input  logic [TW-1:0]     i_idx,
    input  logic [N_IN-1:0]   i_care,
    input  logic [N_IN-1:0]   i_val,
    input  logic              i_en,
    input  logic [N_IN-1:0]   i_a,
    output logic [N_TERM-1:0] o_term
);

    logic [N_IN-1:0] r_care [N_TERM];
    logic [N_IN-1:0] r_val  [N_TERM];
    logic [N_TERM-1:0] r_en;

    // Storage has no reset: the controller's init sweep clears every entry.
    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_care[i_idx] <= i_care;
            r_val[i_idx]  <= i_val;
            r_en[i_idx]   <= i_en;
        end
    end

    always_comb begin
        o_term = '0;
        for (int t = 0; t < N_TERM; t++) begin
            o_term[t] = r_en[t] & (&(~(i_a ^ r_val[t]) | ~r_care[t]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/pla_prog.sv
`default_nettype none
// ============================================================================
// pla_prog: two-stage programmable PLA decoder with init sweep and
//           runtime-writable AND/OR planes.
// Rev 1.0
// ============================================================================
module pla_prog
    import pla_pkg::*;
#(
    parameter int N_IN   = C_PLA_N_IN,
    parameter int N_OUT  = C_PLA_N_OUT,
    parameter int N_TERM = C_PLA_N_TERM,
    parameter int TW     = $clog2(N_TERM)
) (
    input  logic             Rst,
    input  logic             Clk,
    input  logic             CE,
    input  logic [N_IN-1:0]  A,
    input  logic             A_Vld,
    output logic [N_OUT-1:0] Q,
    output logic             Q_Vld,
    output logic             Rdy,
    input  logic             Cfg_We,
    input  logic             Cfg_Sel,
    input  logic [TW-1:0]    Cfg_Idx,
    input  logic [N_IN-1:0]  Cfg_Care,
    input  logic [N_IN-1:0]  Cfg_Val,
    input  logic [N_OUT-1:0] Cfg_Or,
    output logic             Cfg_Err
);

    localparam logic [TW-1:0] C_LAST_IDX = TW'(N_TERM - 1);

    pla_state_t       r_state;
    logic [TW-1:0]    r_cnt;
    logic             r_rdy;
    logic             r_cfg_err;

    logic [N_TERM-1:0] r_term;
    logic              r_s1_vld;
    logic [N_OUT-1:0]  r_q;
    logic              r_q_vld;
    logic [N_OUT-1:0]  r_or [N_TERM];

    logic              w_init;
    logic              w_cfg_ok;
    logic              w_and_we;
    logic              w_or_we;
    logic [TW-1:0]     w_idx;
    logic [N_TERM-1:0] w_term;
    logic [N_OUT-1:0]  w_or_q;

    assign w_init   = (r_state == ST_INIT);
    assign w_cfg_ok = Cfg_We & r_rdy;
    assign w_and_we = ~Rst & (w_init | (w_cfg_ok & (Cfg_Sel == C_SEL_AND)));
    assign w_or_we  = ~Rst & (w_init | (w_cfg_ok & (Cfg_Sel == C_SEL_OR)));
    assign w_idx    = w_init ? r_cnt : Cfg_Idx;

    pla_and_plane #(
        .N_IN   (N_IN),
        .N_TERM (N_TERM),
        .TW     (TW)
    ) u_and_plane (
        .Clk    (Clk),
        .i_we   (w_and_we),
        .i_idx  (w_idx),
        .i_care (w_init ? '0 : Cfg_Care),
        .i_val  (w_init ? '0 : Cfg_Val),
        .i_en   (~w_init),
        .i_a    (A),
        .o_term (w_term)
    );

    // Table writes land on the edge, so a stage sampling the planes on that
    // same edge still sees the previous contents.
    always_ff @(posedge Clk) begin
        if (w_or_we) begin
            r_or[w_idx] <= w_init ? '0 : Cfg_Or;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_rdy     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= Cfg_We & ~r_rdy;
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_rdy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rdy <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_or_q = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (r_term[t]) begin
                w_or_q = w_or_q | r_or[t];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_term   <= '0;
            r_s1_vld <= 1'b0;
            r_q      <= '0;
            r_q_vld  <= 1'b0;
        end else if (CE) begin
            r_term   <= w_term;
            r_s1_vld <= A_Vld & r_rdy;
            r_q_vld  <= r_s1_vld;
            if (r_s1_vld) begin
                r_q <= w_or_q;
            end
        end
    end

    assign Q       = r_q;
    assign Q_Vld   = r_q_vld;
    assign Rdy     = r_rdy;
    assign Cfg_Err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pla_prog.sv
`default_nettype none
// ============================================================================
// tb_pla_prog: directed vector-table bench for the pla_prog decoder.
// Rev 1.0
// ============================================================================
module tb_pla_prog;

    logic        Rst;
    logic        Clk;
    logic        CE;
    logic [5:0]  A;
    logic        A_Vld;
    logic [47:0] Q;
    logic        Q_Vld;
    logic        Rdy;
    logic        Cfg_We;
    logic        Cfg_Sel;
    logic [5:0]  Cfg_Idx;
    logic [5:0]  Cfg_Care;
    logic [5:0]  Cfg_Val;
    logic [47:0] Cfg_Or;
    logic        Cfg_Err;

    int checks = 0;
    int errors = 0;

    pla_prog u_dut (
        .Rst      (Rst),
        .Clk      (Clk),
        .CE       (CE),
        .A        (A),
        .A_Vld    (A_Vld),
        .Q        (Q),
        .Q_Vld    (Q_Vld),
        .Rdy      (Rdy),
        .Cfg_We   (Cfg_We),
        .Cfg_Sel  (Cfg_Sel),
        .Cfg_Idx  (Cfg_Idx),
        .Cfg_Care (Cfg_Care),
        .Cfg_Val  (Cfg_Val),
        .Cfg_Or   (Cfg_Or),
        .Cfg_Err  (Cfg_Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  a;
        logic [47:0] q;
    } vec_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic decode(input logic [5:0] a, output logic [47:0] q, output logic qv);
        A     = a;
        A_Vld = 1'b1;
        tick();
        A_Vld = 1'b0;
        tick();
        q  = Q;
        qv = Q_Vld;
    endtask

    task automatic cfg(input logic sel, input logic [5:0] idx, input logic [5:0] care,
                       input logic [5:0] val, input logic [47:0] orv);
        Cfg_We   = 1'b1;
        Cfg_Sel  = sel;
        Cfg_Idx  = idx;
        Cfg_Care = care;
        Cfg_Val  = val;
        Cfg_Or   = orv;
        tick();
        Cfg_We = 1'b0;
        chk("cfg_err_run", 64'(Cfg_Err), 64'd0);
    endtask

    // Count edges after Rst release until Rdy, keeping A_Vld asserted
    // throughout INIT; Q/Q_Vld must stay zero the whole time.
    task automatic wait_rdy(output int n, output logic bad);
        n   = 0;
        bad = 1'b0;
        A     = 6'h01;
        A_Vld = 1'b1;
        while (!Rdy && n < 200) begin
            tick();
            n++;
            if (!Rdy && (Q !== 48'd0 || Q_Vld !== 1'b0)) bad = 1'b1;
        end
        A_Vld = 1'b0;
    endtask

    vec_t        vecs [8];
    logic [47:0] q;
    logic        qv;
    int          n;
    logic        bad;

    initial begin
        vecs[0] = '{6'h01, 48'h000000000001};
        vecs[1] = '{6'h02, 48'h000000000001};
        vecs[2] = '{6'h05, 48'h000000000000};
        vecs[3] = '{6'h30, 48'h010000000000};
        vecs[4] = '{6'h3F, 48'h010000000000};
        vecs[5] = '{6'h2F, 48'h000000000000};
        vecs[6] = '{6'h31, 48'h010000000000};
        vecs[7] = '{6'h00, 48'h000000000000};

        Rst = 1'b1; CE = 1'b1; A = '0; A_Vld = 1'b0;
        Cfg_We = 1'b0; Cfg_Sel = 1'b0; Cfg_Idx = '0;
        Cfg_Care = '0; Cfg_Val = '0; Cfg_Or = '0;
        tick();
        tick();
        chk("rst_rdy", 64'(Rdy), 64'd0);
        chk("rst_q", 64'(Q), 64'd0);
        chk("rst_qvld", 64'(Q_Vld), 64'd0);
        chk("rst_err", 64'(Cfg_Err), 64'd0);

        // INIT sweep with rejected writes at edges 10 (AND) and 20 (OR)
        Rst = 1'b0; A = 6'h00; A_Vld = 1'b1;
        n = 0; bad = 1'b0;
        while (!Rdy && n < 200) begin
            tick();
            n++;
            if (!Rdy && (Q !== 48'd0 || Q_Vld !== 1'b0)) bad = 1'b1;
            if (n == 9) begin
                Cfg_We = 1'b1; Cfg_Sel = 1'b0; Cfg_Idx = 6'd3;
                Cfg_Care = 6'h00; Cfg_Val = 6'h00;
            end
            if (n == 19) begin
                Cfg_We = 1'b1; Cfg_Sel = 1'b1; Cfg_Idx = 6'd3;
                Cfg_Or = 48'h800000000001;
            end
            if (n == 10) begin
                Cfg_We = 1'b0;
                chk("init_err_pulse_and", 64'(Cfg_Err), 64'd1);
            end
            if (n == 11) chk("init_err_clear", 64'(Cfg_Err), 64'd0);
            if (n == 20) begin
                Cfg_We = 1'b0;
                chk("init_err_pulse_or", 64'(Cfg_Err), 64'd1);
            end
        end
        A_Vld = 1'b0;
        chk("init_len", 64'(n), 64'd64);
        chk("init_quiet", 64'(bad), 64'd0);

        decode(6'h00, q, qv);
        chk("init_write_ignored_q", 64'(q), 64'd0);
        chk("init_write_ignored_vld", 64'(qv), 64'd1);

        cfg(1'b0, 6'd1, 6'h3F, 6'h01, 48'd0);
        cfg(1'b0, 6'd2, 6'h3F, 6'h02, 48'd0);
        cfg(1'b1, 6'd1, 6'h00, 6'h00, 48'h000000000001);
        cfg(1'b1, 6'd2, 6'h00, 6'h00, 48'h000000000001);
        cfg(1'b0, 6'd5, 6'h30, 6'h30, 48'd0);
        cfg(1'b1, 6'd5, 6'h00, 6'h00, 48'h010000000000);

        // Latency: Q_Vld low after first edge, result after second
        A = 6'h01; A_Vld = 1'b1;
        tick();
        A_Vld = 1'b0;
        chk("lat_first_edge_vld", 64'(Q_Vld), 64'd0);
        tick();
        chk("lat_second_edge_q", 64'(Q), 64'h1);
        chk("lat_second_edge_vld", 64'(Q_Vld), 64'd1);
        tick();

        for (int i = 0; i < 8; i++) begin
            decode(vecs[i].a, q, qv);
            chk($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
            chk($sformatf("vec%0d_vld", i), 64'(qv), 64'd1);
        end

        for (int a = 0; a < 64; a++) begin
            decode(6'(a), q, qv);
            chk($sformatf("sweep_%02h_q40", a), 64'(q[40]), (a >= 48) ? 64'd1 : 64'd0);
        end

        // CE freeze with two decodes in flight
        tick();
        A = 6'h01; A_Vld = 1'b1;
        tick();
        A = 6'h30;
        tick();
        chk("ce_pre_q", 64'(Q), 64'h1);
        CE = 1'b0; A = 6'h02;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ce_hold%0d_q", i), 64'(Q), 64'h1);
            chk($sformatf("ce_hold%0d_vld", i), 64'(Q_Vld), 64'd1);
        end
        CE = 1'b1; A_Vld = 1'b0;
        tick();
        chk("ce_resume_q", 64'(Q), 64'h010000000000);
        chk("ce_resume_vld", 64'(Q_Vld), 64'd1);
        tick();
        chk("ce_drain_vld", 64'(Q_Vld), 64'd0);
        chk("ce_drain_q_hold", 64'(Q), 64'h010000000000);

        // OR write on the edge stage 2 loads: old column used
        A = 6'h01; A_Vld = 1'b1;
        tick();
        A_Vld = 1'b0;
        Cfg_We = 1'b1; Cfg_Sel = 1'b1; Cfg_Idx = 6'd1; Cfg_Or = 48'h000000000080;
        tick();
        Cfg_We = 1'b0;
        chk("or_same_edge_old", 64'(Q), 64'h1);
        decode(6'h01, q, qv);
        chk("or_after_write_new", 64'(q), 64'h80);

        // AND write on the edge stage 1 loads: old term used
        A = 6'h02; A_Vld = 1'b1;
        Cfg_We = 1'b1; Cfg_Sel = 1'b0; Cfg_Idx = 6'd2; Cfg_Care = 6'h3F; Cfg_Val = 6'h03;
        tick();
        Cfg_We = 1'b0; A_Vld = 1'b0;
        tick();
        chk("and_same_edge_old", 64'(Q), 64'h1);
        decode(6'h02, q, qv);
        chk("and_after_write_old_val", 64'(q), 64'h0);
        decode(6'h03, q, qv);
        chk("and_after_write_new_val", 64'(q), 64'h1);

        // Reset mid-stream
        A = 6'h30; A_Vld = 1'b1;
        tick(); tick(); tick();
        chk("stream_vld", 64'(Q_Vld), 64'd1);
        Rst = 1'b1;
        tick();
        chk("mid_rst_qvld", 64'(Q_Vld), 64'd0);
        chk("mid_rst_q", 64'(Q), 64'd0);
        chk("mid_rst_rdy", 64'(Rdy), 64'd0);
        Rst = 1'b0;
        wait_rdy(n, bad);
        chk("reinit_len", 64'(n), 64'd64);
        chk("reinit_quiet", 64'(bad), 64'd0);
        decode(6'h01, q, qv);
        chk("reinit_cleared_01", 64'(q), 64'd0);
        chk("reinit_cleared_01_vld", 64'(qv), 64'd1);
        decode(6'h30, q, qv);
        chk("reinit_cleared_30", 64'(q), 64'd0);
        decode(6'h03, q, qv);
        chk("reinit_cleared_03", 64'(q), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
